// File: rtl/ext_wire_pkg.sv
// Shared widths, readback FSM states and the word-select helper for the
// extended-wire readback path.
package ext_wire_pkg;

   localparam int WORD_W         = 16;
   localparam int WIDE_W         = 64;
   localparam int WORDS_PER_WIDE = 4;

   localparam logic [WORD_W-1:0] INVALID_ECHO_DEFAULT = 16'hFFFF;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ECHO = 3'd1,
      W3   = 3'd2,
      W2   = 3'd3,
      W1   = 3'd4,
      W0   = 3'd5
   } state_t;

   // Word presented to the host in a given state, most-significant word first.
   function automatic logic [WORD_W-1:0] word_of(input state_t st,
                                                 input logic [WORD_W-1:0] echo,
                                                 input logic [WIDE_W-1:0] snap);
      logic [WORD_W-1:0] w;
      case (st)
         ECHO:    w = echo;
         W3:      w = snap[63:48];
         W2:      w = snap[47:32];
         W1:      w = snap[31:16];
         W0:      w = snap[15:0];
         default: w = 16'h0000;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/ext_wire_regfile.sv
// NUM_WIRES x 64-bit register file with range-checked writes, per-entry
// updated flags (set beats clear) and a write-through read port.
module ext_wire_regfile
   import ext_wire_pkg::*;
#(
   parameter int NUM_WIRES = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDE_W-1:0]    wide_in,
   input  logic [WORD_W-1:0]    wide_address,
   input  logic                 wide_update,
   input  logic [WORD_W-1:0]    rd_address,
   output logic [WIDE_W-1:0]    rd_data,
   output logic                 rd_ok,
   input  logic                 clr_en,
   input  logic [WORD_W-1:0]    clr_address,
   output logic [NUM_WIRES-1:0] updated
);

   localparam logic [WORD_W-1:0] LIMIT = WORD_W'(NUM_WIRES);

   logic [WIDE_W-1:0]    mem_r [NUM_WIRES];
   logic [NUM_WIRES-1:0] updated_r;
   logic [NUM_WIRES-1:0] updated_nxt_s;
   logic [WIDE_W-1:0]    rd_mem_s;
   logic                 wr_ok_s;

   assign wr_ok_s = wide_update && (wide_address < LIMIT);
   assign rd_ok   = rd_address < LIMIT;
   assign updated = updated_r;

   // Read port: a write to the same entry in this cycle is forwarded.
   always_comb begin
      rd_mem_s = 64'd0;
      for (int i = 0; i < NUM_WIRES; i++) begin
         rd_mem_s = (rd_address == WORD_W'(i)) ? mem_r[i] : rd_mem_s;
      end
      if (!rd_ok) begin
         rd_data = 64'd0;
      end else if (wr_ok_s && (wide_address == rd_address)) begin
         rd_data = wide_in;
      end else begin
         rd_data = rd_mem_s;
      end
   end

   // Next updated flags; a set in the same cycle as a clear wins.
   always_comb begin
      updated_nxt_s = updated_r;
      for (int i = 0; i < NUM_WIRES; i++) begin
         updated_nxt_s[i] = (wr_ok_s && (wide_address == WORD_W'(i))) ? 1'b1 :
                            (clr_en && (clr_address == WORD_W'(i)))  ? 1'b0 :
                            updated_r[i];
      end
   end

   // Storage and flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_WIRES; i++) begin
            mem_r[i] <= 64'd0;
         end
         updated_r <= '0;
      end else begin
         for (int i = 0; i < NUM_WIRES; i++) begin
            if (wr_ok_s && (wide_address == WORD_W'(i))) begin
               mem_r[i] <= wide_in;
            end
         end
         updated_r <= updated_nxt_s;
      end
   end

endmodule

// File: rtl/extended_wire_serializer.sv
// Readback half of the extended-wire protocol: snapshots one 64-bit entry on
// request and returns echo + four 16-bit words, one per host read strobe.
module extended_wire_serializer
   import ext_wire_pkg::*;
#(
   parameter int                NUM_WIRES    = 16,
   parameter logic [WORD_W-1:0] INVALID_ECHO = INVALID_ECHO_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDE_W-1:0]    wide_in,
   input  logic [WORD_W-1:0]    wide_address,
   input  logic                 wide_update,
   input  logic [WORD_W-1:0]    req_address,
   input  logic                 req_valid,
   input  logic                 read,
   output logic [WORD_W-1:0]    data_out,
   output logic                 data_valid,
   output logic                 busy,
   output logic                 addr_error,
   output logic [NUM_WIRES-1:0] updated
);

   state_t            state_r, state_nxt_s;
   logic [WIDE_W-1:0] snap_r, snap_nxt_s;
   logic [WORD_W-1:0] echo_r, echo_nxt_s;
   logic [WORD_W-1:0] addr_r, addr_nxt_s;
   logic              addr_ok_r, addr_ok_nxt_s;
   logic              dirty_r, dirty_nxt_s;
   logic              addr_error_nxt_s;
   logic              clr_s;
   logic [WIDE_W-1:0] rd_data_s;
   logic              rd_ok_s;
   logic [WORD_W-1:0] data_out_r;
   logic              data_valid_r, busy_r, addr_error_r;

   ext_wire_regfile #(.NUM_WIRES(NUM_WIRES)) u_regfile (
      .clk          (clk),
      .reset        (reset),
      .wide_in      (wide_in),
      .wide_address (wide_address),
      .wide_update  (wide_update),
      .rd_address   (req_address),
      .rd_data      (rd_data_s),
      .rd_ok        (rd_ok_s),
      .clr_en       (clr_s),
      .clr_address  (addr_r),
      .updated      (updated)
   );

   // FSM next state, snapshot capture and completion clear.
   always_comb begin
      state_nxt_s      = state_r;
      snap_nxt_s       = snap_r;
      echo_nxt_s       = echo_r;
      addr_nxt_s       = addr_r;
      addr_ok_nxt_s    = addr_ok_r;
      dirty_nxt_s      = dirty_r;
      addr_error_nxt_s = 1'b0;
      clr_s            = 1'b0;
      case (state_r)
         IDLE: begin
            if (req_valid) begin
               state_nxt_s      = ECHO;
               snap_nxt_s       = rd_data_s;
               echo_nxt_s       = rd_ok_s ? req_address : INVALID_ECHO;
               addr_nxt_s       = req_address;
               addr_ok_nxt_s    = rd_ok_s;
               dirty_nxt_s      = 1'b0;
               addr_error_nxt_s = ~rd_ok_s;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ECHO:    state_nxt_s = read ? W3 : ECHO;
         W3:      state_nxt_s = read ? W2 : W3;
         W2:      state_nxt_s = read ? W1 : W2;
         W1:      state_nxt_s = read ? W0 : W1;
         W0: begin
            if (read) begin
               state_nxt_s = IDLE;
               clr_s       = addr_ok_r & ~dirty_r;
            end else begin
               state_nxt_s = W0;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
      // A write that lands after the snapshot keeps the entry flagged.
      if ((state_r != IDLE) && wide_update && (wide_address == addr_r)) begin
         dirty_nxt_s = 1'b1;
      end else begin
         dirty_nxt_s = dirty_nxt_s;
      end
   end

   // State, snapshot and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         snap_r       <= 64'd0;
         echo_r       <= 16'h0000;
         addr_r       <= 16'h0000;
         addr_ok_r    <= 1'b0;
         dirty_r      <= 1'b0;
         data_out_r   <= 16'h0000;
         data_valid_r <= 1'b0;
         busy_r       <= 1'b0;
         addr_error_r <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         snap_r       <= snap_nxt_s;
         echo_r       <= echo_nxt_s;
         addr_r       <= addr_nxt_s;
         addr_ok_r    <= addr_ok_nxt_s;
         dirty_r      <= dirty_nxt_s;
         data_out_r   <= word_of(state_nxt_s, echo_nxt_s, snap_nxt_s);
         data_valid_r <= (state_nxt_s != IDLE);
         busy_r       <= (state_nxt_s != IDLE);
         addr_error_r <= addr_error_nxt_s;
      end
   end

   assign data_out   = data_out_r;
   assign data_valid = data_valid_r;
   assign busy       = busy_r;
   assign addr_error = addr_error_r;

endmodule

// File: tb/tb_extended_wire_serializer.sv
// Self-checking bench: directed test-plan scenarios plus random traffic,
// compared every cycle against a transaction-level reference model.
module tb_extended_wire_serializer;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] wide_in;
   logic [15:0] wide_address;
   logic        wide_update;
   logic [15:0] req_address;
   logic        req_valid;
   logic        read;
   logic [15:0] data_out;
   logic        data_valid;
   logic        busy;
   logic        addr_error;
   logic [15:0] updated;

   int checks = 0;
   int errors = 0;

   // Reference model: contents, flags and the word list of the open transaction.
   logic [63:0] m_mem [16];
   logic [15:0] m_upd;
   logic [15:0] m_words [$];
   int          m_pos;
   logic [15:0] m_addr;
   logic        m_ok;
   logic        m_dirty;

   extended_wire_serializer #(.NUM_WIRES(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .wide_in      (wide_in),
      .wide_address (wide_address),
      .wide_update  (wide_update),
      .req_address  (req_address),
      .req_valid    (req_valid),
      .read         (read),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .busy         (busy),
      .addr_error   (addr_error),
      .updated      (updated)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, advance the model, then compare all outputs.
   task automatic step(input logic rst, input logic wu, input logic [15:0] wa,
                       input logic [63:0] wi, input logic rv, input logic [15:0] ra,
                       input logic rd);
      bit          act;
      bit          ok;
      logic        exp_err;
      logic [63:0] snap;
      logic [15:0] exp_do;
      reset = rst; wide_update = wu; wide_address = wa; wide_in = wi;
      req_valid = rv; req_address = ra; read = rd;
      act = (m_words.size() != 0);
      exp_err = 1'b0;
      if (rst) begin
         for (int i = 0; i < 16; i++) m_mem[i] = 64'd0;
         m_upd = 16'h0000;
         m_words.delete();
      end else begin
         if (!act && rv) begin
            ok = (ra < 16'd16);
            snap = !ok ? 64'd0 : ((wu && wa == ra) ? wi : m_mem[ra[3:0]]);
            m_words = '{ok ? ra : 16'hFFFF, snap[63:48], snap[47:32], snap[31:16], snap[15:0]};
            m_pos = 0; m_addr = ra; m_ok = ok; m_dirty = 1'b0; exp_err = !ok;
         end else if (act && rd) begin
            m_pos++;
            if (m_pos == 5) begin
               if (m_ok && !m_dirty) m_upd[m_addr[3:0]] = 1'b0;
               m_words.delete();
            end
         end
         if (act && wu && wa == m_addr) m_dirty = 1'b1;
         if (wu && wa < 16'd16) begin
            m_mem[wa[3:0]] = wi;
            m_upd[wa[3:0]] = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      exp_do = (m_words.size() != 0) ? m_words[m_pos] : 16'h0000;
      check("data_out",   64'(data_out),   64'(exp_do));
      check("data_valid", 64'(data_valid), 64'(m_words.size() != 0));
      check("busy",       64'(busy),       64'(m_words.size() != 0));
      check("addr_error", 64'(addr_error), 64'(exp_err));
      check("updated",    64'(updated),    64'(m_upd));
   endtask

   task automatic idle();                          step(1'b0, 1'b0, 16'd0, 64'd0, 1'b0, 16'd0, 1'b0); endtask
   task automatic rd();                            step(1'b0, 1'b0, 16'd0, 64'd0, 1'b0, 16'd0, 1'b1); endtask
   task automatic req(input logic [15:0] a);       step(1'b0, 1'b0, 16'd0, 64'd0, 1'b1, a,     1'b0); endtask
   task automatic wr(input logic [15:0] a, input logic [63:0] v); step(1'b0, 1'b1, a, v, 1'b0, 16'd0, 1'b0); endtask

   initial begin
      step(1'b1, 1'b0, 16'd0, 64'd0, 1'b0, 16'd0, 1'b0);
      step(1'b1, 1'b0, 16'd0, 64'd0, 1'b0, 16'd0, 1'b0);
      check("reset_data_out", 64'(data_out), 64'h0);

      // Basic read of entry 7.
      wr(16'd7, 64'h123454326789a987);
      check("basic_upd_set", 64'(updated[7]), 64'h1);
      req(16'd7);  check("basic_echo", 64'(data_out), 64'h0007);
      rd();        check("basic_w3", 64'(data_out), 64'h1234);
      rd();        check("basic_w2", 64'(data_out), 64'h5432);
      rd();        check("basic_w1", 64'(data_out), 64'h6789);
      rd();        check("basic_w0", 64'(data_out), 64'ha987);
      rd();        check("basic_done_valid", 64'(data_valid), 64'h0);
      check("basic_upd_clr", 64'(updated[7]), 64'h0);

      // Tear protection on entry 8.
      wr(16'd8, 64'h8765432101234567);
      req(16'd8);
      rd();        check("tear_w3", 64'(data_out), 64'h8765);
      wr(16'd8, 64'h0);
      rd();        check("tear_w2", 64'(data_out), 64'h4321);
      rd();        check("tear_w1", 64'(data_out), 64'h0123);
      rd();        check("tear_w0", 64'(data_out), 64'h4567);
      rd();        check("tear_upd_kept", 64'(updated[8]), 64'h1);
      req(16'd8);  check("tear2_echo", 64'(data_out), 64'h0008);
      rd();        check("tear2_w3", 64'(data_out), 64'h0000);
      rd(); rd(); rd(); rd();

      // Same-cycle write and request: bypass.
      step(1'b0, 1'b1, 16'd9, 64'h9876543210123456, 1'b1, 16'd9, 1'b0);
      check("byp_echo", 64'(data_out), 64'h0009);
      rd();        check("byp_w3", 64'(data_out), 64'h9876);
      rd();        check("byp_w2", 64'(data_out), 64'h5432);
      rd();        check("byp_w1", 64'(data_out), 64'h1012);
      rd();        check("byp_w0", 64'(data_out), 64'h3456);
      rd();

      // Out-of-range request.
      req(16'h0020);
      check("inv_err", 64'(addr_error), 64'h1);
      check("inv_echo", 64'(data_out), 64'hFFFF);
      rd();        check("inv_err_pulse", 64'(addr_error), 64'h0);
      check("inv_w3", 64'(data_out), 64'h0000);
      rd(); rd(); rd(); rd();

      // Ignored strobes: request while busy, read while idle.
      wr(16'd7, 64'h0a0b0c0d0e0f1011);
      req(16'd7);
      req(16'd3);  check("ign_echo", 64'(data_out), 64'h0007);
      rd(); rd(); rd(); rd(); rd();
      rd();        check("ign_idle_do", 64'(data_out), 64'h0000);
      check("ign_idle_busy", 64'(busy), 64'h0);

      // Reset in W2.
      wr(16'd5, 64'hdeadbeefcafef00d);
      req(16'd7); rd(); rd();
      step(1'b1, 1'b0, 16'd0, 64'd0, 1'b0, 16'd0, 1'b0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_upd", 64'(updated), 64'h0);
      req(16'd5); rd(); check("rst_entry5", 64'(data_out), 64'h0000);
      rd(); rd(); rd(); rd();
      idle();

      // Random traffic.
      for (int n = 0; n < 1500; n++) begin
         logic        r_rst, r_wu, r_rv, r_rd;
         logic [15:0] r_wa, r_ra;
         logic [63:0] r_wi;
         r_rst = ($urandom_range(0, 299) == 0);
         r_wu  = ($urandom_range(0, 3) == 0);
         r_rv  = ($urandom_range(0, 5) == 0);
         r_rd  = ($urandom_range(0, 1) == 0);
         r_wa  = 16'($urandom_range(0, 19));
         r_ra  = ($urandom_range(0, 3) == 0) ? r_wa : 16'($urandom_range(0, 20));
         r_wi  = {32'($urandom), 32'($urandom)};
         step(r_rst, r_wu, r_wa, r_wi, r_rv, r_ra, r_rd);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
